// File: rtl/regfile_32x64.sv
// regfile_32x64: architectural register file for the pipelined LEGv8 datapath.
// 2**ADDR_WIDTH registers of DATA_WIDTH bits, one synchronous write port and two
// combinational read ports. Register ZERO_REG (XZR) has no storage and always reads 0.
// Optional feature macro: REGFILE_BYPASS_EN enables a same-cycle write-through bypass
// on both read ports. Without it, reads return the stored (pre-edge) value.
// Reset is asynchronous and active-low; it clears every register immediately.

module regfile_32x64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  // One-hot write enables, all gated by write_en.
  logic [NumRegs-1:0] wr_dec;

  // Current contents of every register as seen by the read muxes.
  logic [NumRegs-1:0][DATA_WIDTH-1:0] reg_vals;

  // Write address decode: exactly one line high when write_en=1, none otherwise.
  always_comb begin
    wr_dec = '0;
    if (write_en) begin
      wr_dec[write_addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      // XZR: no storage, its enable line is simply left unused.
      logic unused_en;
      assign unused_en   = wr_dec[i];
      assign reg_vals[i] = '0;
    end else begin : g_store
      logic [DATA_WIDTH-1:0] reg_d;
      logic [DATA_WIDTH-1:0] reg_q;

      // Next state: load write_data when this register's enable line is high.
      always_comb begin
        reg_d = reg_q;
        if (wr_dec[i]) begin
          reg_d = write_data;
        end
      end

      // Storage flop; reset wins over any write on the same edge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign reg_vals[i] = reg_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Bypass is suppressed during reset so reads stay 0 while reset is low.
  logic bypass_ok;
  assign bypass_ok = reset & write_en & (write_addr != ZeroAddr);

  // Read ports with write-through bypass for the WB-to-ID hazard.
  always_comb begin
    read_data1 = reg_vals[read_addr1];
    read_data2 = reg_vals[read_addr2];
    if (bypass_ok && (read_addr1 == write_addr)) begin
      read_data1 = write_data;
    end
    if (bypass_ok && (read_addr2 == write_addr)) begin
      read_data2 = write_data;
    end
  end
`else
  // Read ports: plain combinational muxes over the stored values.
  always_comb begin
    read_data1 = reg_vals[read_addr1];
    read_data2 = reg_vals[read_addr2];
  end
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64 (either build of REGFILE_BYPASS_EN).
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  int n_cmp;
  int n_err;

  regfile_32x64 #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5),
    .ZERO_REG  (31)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write one register on the next rising edge; inputs change at the falling edge.
  task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] exp1;
    logic [63:0] exp2;
    base       = 64'h1111_0000_0000_0000;
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = '0;
    read_addr2 = '0;

    // Reset held: every address reads 0 on both ports.
    #1;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      #1;
      check("rst_low_p1", read_data1, 64'h0);
      check("rst_low_p2", read_data2, 64'h0);
    end

    // Release reset between edges and sweep again.
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      #1;
      check("post_rst_p1", read_data1, 64'h0);
      check("post_rst_p2", read_data2, 64'h0);
    end

    // Write base+i to every register, then read all back (port 2 reversed).
    for (int i = 0; i < 32; i++) begin
      write_reg(5'(i), base + 64'(i));
    end
    @(negedge clk);
    write_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(31 - i);
      #1;
      exp1 = (i == 31) ? 64'h0 : base + 64'(i);
      exp2 = (i == 0)  ? 64'h0 : base + 64'(31 - i);
      check("wr_all_p1", read_data1, exp1);
      check("wr_all_p2", read_data2, exp2);
    end

    // Write disabled: register 5 must keep its value.
    @(negedge clk);
    write_en   = 1'b0;
    write_addr = 5'd5;
    write_data = 64'hDEAD_BEEF_DEAD_BEEF;
    read_addr1 = 5'd5;
    @(posedge clk);
    #1;
    check("wr_dis_r5", read_data1, 64'h1111_0000_0000_0005);

    // Both ports on the same register.
    read_addr1 = 5'd7;
    read_addr2 = 5'd7;
    #1;
    check("dual_p1_r7", read_data1, 64'h1111_0000_0000_0007);
    check("dual_p2_r7", read_data2, 64'h1111_0000_0000_0007);

    // Write to XZR: reads 0 in flight and after, and no other register disturbed.
    @(negedge clk);
    write_en   = 1'b1;
    write_addr = 5'd31;
    write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    read_addr1 = 5'd31;
    read_addr2 = 5'd30;
    #1;
    check("xzr_inflight", read_data1, 64'h0);
    @(posedge clk);
    #1;
    check("xzr_after", read_data1, 64'h0);
    check("xzr_r30_kept", read_data2, 64'h1111_0000_0000_001E);
    @(negedge clk);
    write_en = 1'b0;
    for (int i = 0; i < 31; i++) begin
      read_addr1 = 5'(i);
      #1;
      check("xzr_no_alias", read_data1, base + 64'(i));
    end

    // Same-cycle read/write of register 3.
    @(negedge clk);
    write_en   = 1'b1;
    write_addr = 5'd3;
    write_data = 64'h0000_0000_0000_ABCD;
    read_addr1 = 5'd3;
    read_addr2 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rw3_before", read_data1, 64'h0000_0000_0000_ABCD);
`else
    check("rw3_before", read_data1, 64'h1111_0000_0000_0003);
`endif
    check("rw3_other_port", read_data2, 64'h1111_0000_0000_0004);
    @(posedge clk);
    #1;
    check("rw3_after", read_data1, 64'h0000_0000_0000_ABCD);

    // Back-to-back writes to register 10: last one wins.
    read_addr1 = 5'd10;
    write_reg(5'd10, 64'h0123_4567_89AB_CDEF);
    check("b2b_first", read_data1, 64'h0123_4567_89AB_CDEF);
    write_reg(5'd10, 64'hFEDC_BA98_7654_3210);
    check("b2b_last", read_data1, 64'hFEDC_BA98_7654_3210);
    @(negedge clk);
    write_en = 1'b0;

    // Async reset between edges clears outputs before the next edge.
    read_addr1 = 5'd3;
    read_addr2 = 5'd10;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_r3", read_data1, 64'h0);
    check("async_rst_r10", read_data2, 64'h0);

    // Write while reset low is dropped (and not bypassed).
    write_en   = 1'b1;
    write_addr = 5'd4;
    write_data = 64'h5555_5555_5555_5555;
    read_addr1 = 5'd4;
    #1;
    check("rst_wr_inflight", read_data1, 64'h0);
    @(posedge clk);
    #1;
    check("rst_wr_dropped", read_data1, 64'h0);

    // Deassert reset; first write edge afterwards is honoured.
    @(negedge clk);
    reset      = 1'b1;
    write_en   = 1'b1;
    write_addr = 5'd12;
    write_data = 64'hCAFE_F00D_0000_0012;
    read_addr1 = 5'd4;
    read_addr2 = 5'd12;
    @(posedge clk);
    #1;
    check("post_rst_r4", read_data1, 64'h0);
    check("first_wr_r12", read_data2, 64'hCAFE_F00D_0000_0012);
    @(negedge clk);
    write_en   = 1'b0;
    read_addr1 = 5'd7;
    #1;
    check("post_rst_r7", read_data1, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
